counter_sequencer: RTL and testbench

- Controller that sequences an external WIDTH-bit enable-driven up-counter (synchronous active-high clear, increments on each clock edge where its enable is high).
- Generates the counter's clear and enable strobes at a selectable rate.
- Supports start/stop/pause, and free-run or one-shot-to-limit operation, with feedback taken from the counter's value.
- Sits between board switches/keys (Start/Stop/Mode/RateSel) and the counter datapath.

---
 rtl/counter_seq_pkg.sv | 21 ++
 rtl/rate_divider.sv | 36 +++
 rtl/counter_sequencer.sv | 119 +++++++++++
 tb/tb_counter_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg: shared definitions for counter_sequencer.
//   - state_t : controller FSM state (IDLE/CLEAR/RUN/HOLD, 2-bit)
//   - RATE_*  : RateSel encodings
//   - STATE_W : width of the exported State port
package counter_seq_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [1:0] RATE_FULL = 2'd0;
  localparam logic [1:0] RATE_DIV1 = 2'd1;
  localparam logic [1:0] RATE_DIV2 = 2'd2;
  localparam logic [1:0] RATE_DIV3 = 2'd3;

endpackage

// File: rtl/rate_divider.sv
// rate_divider: DIV_W-bit down-counter that paces the count enable.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset (count -> 0)
//   i_load         : load i_load_val (highest priority)
//   i_load_val     : value loaded by i_load
//   i_hold         : freeze the count
//   i_reload       : value taken when the count reaches zero and is not held
//   o_tick         : high while count == 0
module rate_divider #(
  parameter int unsigned DIV_W = 26
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_load_val,
  input  logic             i_hold,
  input  logic [DIV_W-1:0] i_reload,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (!i_hold) begin
      if (r_count == '0) r_count <= i_reload;
      else               r_count <= r_count - 1'b1;
    end
  end

  assign o_tick = (r_count == '0);

endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: drives clear/enable strobes of an external WIDTH-bit
// up-counter with start/stop/pause, free-run or one-shot-to-Limit operation.
// Ports:
//   Clock, Resetn       : clock, asynchronous active-low reset
//   Start, Stop         : start/resume and pause/abort requests (levels)
//   Mode                : 0 free-run, 1 one-shot until CounterValue==Limit
//   RateSel             : 0 enable every cycle, 1/2/3 one per DIVn+1 cycles
//   Limit, CounterValue : one-shot terminal value, counter feedback
//   CountEnable         : counter enable strobe
//   CountClear          : counter synchronous clear strobe
//   Busy, Done, State   : status (Done is a one-cycle completion pulse)
// Optional: define COUNTER_SEQUENCER_AUTO_RESTART_EN to re-clear and restart
// after each one-shot completion instead of returning to IDLE.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 26,
  parameter int unsigned DIV1  = 49999999,
  parameter int unsigned DIV2  = 24999999,
  parameter int unsigned DIV3  = 12499999
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Mode,
  input  logic [1:0]       RateSel,
  input  logic [WIDTH-1:0] Limit,
  input  logic [WIDTH-1:0] CounterValue,
  output logic             CountEnable,
  output logic             CountClear,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       State
);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_done;
  logic             w_tick;
  logic             w_terminal;
  logic             w_div_load;
  logic             w_div_hold;
  logic [DIV_W-1:0] w_reload;

  assign w_terminal = (r_state == ST_RUN) && Mode && (CounterValue == Limit);

  always_comb begin
    w_reload = '0;
    case (RateSel)
      RATE_FULL: w_reload = '0;
      RATE_DIV1: w_reload = DIV_W'(DIV1);
      RATE_DIV2: w_reload = DIV_W'(DIV2);
      RATE_DIV3: w_reload = DIV_W'(DIV3);
      default:   w_reload = '0;
    endcase
  end

  // Divider runs only on RUN cycles that issue or wait for an enable; a Stop
  // or terminal cycle freezes it so a later resume continues the same period.
  assign w_div_load = (r_state == ST_CLEAR);
  assign w_div_hold = (r_state != ST_RUN) || Stop || w_terminal;

  rate_divider #(
    .DIV_W (DIV_W)
  ) u_rate_divider (
    .i_clk      (Clock),
    .i_rst_n    (Resetn),
    .i_load     (w_div_load),
    .i_load_val ('0),
    .i_hold     (w_div_hold),
    .i_reload   (w_reload),
    .o_tick     (w_tick)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_terminal;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (Start && !Stop) w_next_state = ST_CLEAR;
      ST_CLEAR: w_next_state = ST_RUN;
      ST_RUN: begin
        if (w_terminal) begin
`ifdef COUNTER_SEQUENCER_AUTO_RESTART_EN
          w_next_state = ST_CLEAR;
`else
          w_next_state = ST_IDLE;
`endif
        end else if (Stop) begin
          w_next_state = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (Stop)       w_next_state = ST_IDLE;
        else if (Start) w_next_state = ST_RUN;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    CountEnable = (r_state == ST_RUN) && w_tick && !Stop && !w_terminal;
    CountClear  = (r_state == ST_CLEAR);
    Busy        = (r_state != ST_IDLE);
    Done        = r_done;
    State       = r_state;
  end

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;

  localparam int D1 = 3;
  localparam int D2 = 5;
  localparam int D3 = 7;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       Start, Stop, Mode;
  logic [1:0] RateSel;
  logic [7:0] Limit;
  logic [7:0] cnt;
  logic       CountEnable, CountClear, Busy, Done;
  logic [1:0] State;

  counter_sequencer #(
    .WIDTH (8),
    .DIV_W (26),
    .DIV1  (D1),
    .DIV2  (D2),
    .DIV3  (D3)
  ) dut (
    .Clock        (Clock),
    .Resetn       (Resetn),
    .Start        (Start),
    .Stop         (Stop),
    .Mode         (Mode),
    .RateSel      (RateSel),
    .Limit        (Limit),
    .CounterValue (cnt),
    .CountEnable  (CountEnable),
    .CountClear   (CountClear),
    .Busy         (Busy),
    .Done         (Done),
    .State        (State)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int en_q[$];
  int clr_q[$];
  int done_q[$];

  // Reference model: controller described as "is it active / clearing /
  // paused" plus the number of cycles left before the next enable.
  int m_active = 0, m_clearing = 0, m_paused = 0, m_wait = 0, m_done = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int period(input int rs);
    case (rs)
      1: return D1 + 1;
      2: return D2 + 1;
      3: return D3 + 1;
      default: return 1;
    endcase
  endfunction

  task automatic model_reset();
    m_active = 0; m_clearing = 0; m_paused = 0; m_wait = 0; m_done = 0;
  endtask

  task automatic step();
    int e_en, e_clr, e_state;
    int n_active, n_clearing, n_paused, n_wait, n_done;
    int a_en, a_clr;
    @(negedge Clock);
    e_state = (m_active == 0) ? 0 : (m_clearing != 0) ? 1 : (m_paused != 0) ? 3 : 2;
    e_en = 0; e_clr = 0;
    n_active = m_active; n_clearing = m_clearing; n_paused = m_paused;
    n_wait = m_wait; n_done = 0;
    if (m_active == 0) begin
      if (Start && !Stop) begin n_active = 1; n_clearing = 1; end
    end else if (m_clearing != 0) begin
      e_clr = 1; n_clearing = 0; n_wait = 0;
    end else if (m_paused != 0) begin
      if (Stop) begin n_active = 0; n_paused = 0; end
      else if (Start) n_paused = 0;
    end else if (Mode && (cnt == Limit)) begin
      n_done = 1;
`ifdef COUNTER_SEQUENCER_AUTO_RESTART_EN
      n_clearing = 1;
`else
      n_active = 0;
`endif
    end else if (Stop) begin
      n_paused = 1;
    end else if (m_wait == 0) begin
      e_en = 1; n_wait = period(int'(RateSel)) - 1;
    end else begin
      n_wait = m_wait - 1;
    end
    check("CountEnable", int'(CountEnable), e_en);
    check("CountClear", int'(CountClear), e_clr);
    check("Busy", int'(Busy), m_active);
    check("Done", int'(Done), m_done);
    check("State", int'(State), e_state);
    a_en = int'(CountEnable);
    a_clr = int'(CountClear);
    if (a_en != 0) en_q.push_back(cyc);
    if (a_clr != 0) clr_q.push_back(cyc);
    if (Done) done_q.push_back(cyc);
    @(posedge Clock);
    #1;
    if (a_clr != 0) cnt = '0;
    else if (a_en != 0) cnt = cnt + 8'd1;
    m_active = n_active; m_clearing = n_clearing; m_paused = n_paused;
    m_wait = n_wait; m_done = n_done;
    cyc++;
  endtask

  task automatic async_reset();
    #2 Resetn = 1'b0;
    #1;
    check("rst_State", int'(State), 0);
    check("rst_CountEnable", int'(CountEnable), 0);
    check("rst_Busy", int'(Busy), 0);
    check("rst_Done", int'(Done), 0);
    model_reset();
    @(posedge Clock);
    #1 Resetn = 1'b1;
    cyc++;
  endtask

  task automatic clear_logs();
    en_q.delete(); clr_q.delete(); done_q.delete();
  endtask

  task automatic abort();
    Start = 0; Stop = 1;
    repeat (4) step();
    Stop = 0;
  endtask

  task automatic kick();
    Start = 1; step(); Start = 0;
  endtask

  initial begin
    int s;
    Resetn = 1'b0; Start = 0; Stop = 0; Mode = 0; RateSel = 0; Limit = 0; cnt = '0;
    repeat (3) @(posedge Clock);
    #1;
    check("init_State", int'(State), 0);
    check("init_Busy", int'(Busy), 0);
    check("init_CountEnable", int'(CountEnable), 0);
    check("init_CountClear", int'(CountClear), 0);
    check("init_Done", int'(Done), 0);
    Resetn = 1'b1;

    // Free-run at full rate: one clear, then an enable every cycle; wrap.
    clear_logs();
    Mode = 0; RateSel = 0;
    kick();
    step();
    repeat (255) step();
    check("fr_cnt_255", int'(cnt), 255);
    step();
    check("fr_cnt_wrap", int'(cnt), 0);
    check("fr_enables", en_q.size(), 256);
    check("fr_clears", clr_q.size(), 1);

    // Reset while running.
    repeat (5) step();
    async_reset();
    repeat (2) step();

    // One-shot to 5 with one enable per 4 cycles.
    clear_logs();
    Mode = 1; RateSel = 1; Limit = 5;
    kick();
    for (int i = 0; i < 60 && done_q.size() == 0; i++) step();
    check("os5_enables", en_q.size(), 5);
    check("os5_done_seen", done_q.size(), 1);
    if (en_q.size() == 5 && clr_q.size() == 1 && done_q.size() == 1) begin
      check("os5_first_en", en_q[0] - clr_q[0], 1);
      for (int i = 1; i < 5; i++) check("os5_gap", en_q[i] - en_q[i-1], 4);
      check("os5_done_lat", done_q[0] - en_q[4], 2);
    end
    step();
`ifndef COUNTER_SEQUENCER_AUTO_RESTART_EN
    check("os5_idle", int'(State), 0);
`endif
    abort();

    // Limit 0: completes on the first RUN cycle with no enables.
    clear_logs();
    Mode = 1; RateSel = 0; Limit = 0;
    kick();
    for (int i = 0; i < 10 && done_q.size() == 0; i++) step();
    check("lim0_enables", en_q.size(), 0);
    check("lim0_done_seen", done_q.size(), 1);
    if (done_q.size() == 1 && clr_q.size() >= 1)
      check("lim0_done_lat", done_q[0] - clr_q[0], 2);
`ifndef COUNTER_SEQUENCER_AUTO_RESTART_EN
    check("lim0_busy", int'(Busy), 0);
`endif
    abort();

    // Pause with divider at 2, resume, then abort from HOLD.
    clear_logs();
    Mode = 0; RateSel = 1;
    kick();
    step();          // CLEAR
    step();          // RUN, enable, reload 3
    step();          // divider 3
    Stop = 1; step(); Stop = 0;  // divider 2, pause
    repeat (10) step();
    check("hold_no_en", en_q.size(), 1);
    check("hold_state", int'(State), 3);
    s = cyc;
    Start = 1; step(); Start = 0;
    repeat (5) step();
    if (en_q.size() >= 2) check("resume_en_lat", en_q[1] - s, 3);
    else check("resume_en_seen", en_q.size(), 2);
    Stop = 1; step();
    Start = 1; step();
    Start = 0; Stop = 0; step();
    check("abort_idle", int'(State), 0);
    check("abort_no_done", done_q.size(), 0);

`ifdef COUNTER_SEQUENCER_AUTO_RESTART_EN
    // Periodic 0..2 sequencing.
    clear_logs();
    Mode = 1; RateSel = 0; Limit = 2;
    kick();
    repeat (20) step();
    check("ar_done_count", (done_q.size() >= 3) ? 1 : 0, 1);
    for (int i = 1; i < done_q.size(); i++) check("ar_period", done_q[i] - done_q[i-1], 4);
    check("ar_busy", int'(Busy), 1);
    abort();
`endif

    // Randomized operation against the model.
    for (int i = 0; i < 4000; i++) begin
      Start = ($urandom_range(0, 7) == 0);
      Stop  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) Mode = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) RateSel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0)
        Limit = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
      if ($urandom_range(0, 599) == 0) async_reset();
      else step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
